// File: rtl/clk_period_mon_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : clk_period_mon_pkg
// Purpose  : Shared types, defaults and helpers for the clock-period monitor.
//            - ch_state_t : per-channel measurement FSM state
//            - cnt_max()  : saturation value of a period counter of width w,
//                           i.e. CNT_MAX = 2^CNT_W - 1
//            - abs_diff() : unsigned |a - b| that never wraps
// Ports    : none (package)
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
package clk_period_mon_pkg;

  // Default configuration of the monitor.
  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_CNT_W    = 12;
  localparam int DEF_LOCK_CNT = 4;

  // Width of the abs_diff() result. Callers pass counter values of at most
  // 32 bits, so one extra bit is enough to hold any difference without wrap;
  // for a CNT_W-bit counter only the low CNT_W+1 bits can ever be non-zero.
  localparam int DIFF_W = 33;

  // Per-channel FSM state. IDLE waits for an arming edge, MEASURE counts
  // clk cycles between rising edges.
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } ch_state_t;

  // Saturation value of a w-bit period counter (CNT_MAX = 2^w - 1).
  // Reaching it without a rising edge means the monitored clock stopped.
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  // Absolute difference computed one bit wider than the operands so that
  // the subtraction can never wrap.
  function automatic logic [DIFF_W-1:0] abs_diff(input logic [31:0] a,
                                                 input logic [31:0] b);
    logic [DIFF_W-1:0] r_res;
    if (a >= b) begin
      r_res = {1'b0, a} - {1'b0, b};
    end else begin
      r_res = {1'b0, b} - {1'b0, a};
    end
    return r_res;
  endfunction

endpackage : clk_period_mon_pkg
`default_nettype wire

// File: rtl/clk_period_ch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : clk_period_ch
// Purpose  : One channel of the clock-period monitor. Detects rising edges of
//            a monitored signal, counts clk cycles between them, compares the
//            measured period against exp_period +/- tol, tracks lock and
//            keeps sticky error/timeout flags.
// Ports    : clk        - system clock
//            rst        - asynchronous active-high reset
//            en         - enable; low forces IDLE and drops lock
//            mon_in     - monitored clock / strobe
//            exp_period - expected period in clk cycles
//            tol        - allowed absolute deviation (inclusive)
//            err_clr    - clears err and timeout (a same-cycle set wins)
//            period_out - last measured period
//            period_vld - one-cycle pulse when period_out updates
//            locked     - LOCK_CNT consecutive good periods seen
//            err        - sticky: bad period or timeout
//            timeout    - sticky: counter saturated without an edge
// Options  : CLK_MON_SYNC_EN - insert a 2-flop synchronizer on mon_in
//            (adds 2 cycles of latency, measured periods unchanged).
// Revision : 1.0 - initial release
// ============================================================================
module clk_period_ch
  import clk_period_mon_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mon_in,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] tol,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period_out,
  output logic             period_vld,
  output logic             locked,
  output logic             err,
  output logic             timeout
);

  localparam int                  c_GOOD_W  = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]    c_CNT_MAX = CNT_W'(cnt_max(CNT_W));
  localparam logic [c_GOOD_W-1:0] c_LOCK    = c_GOOD_W'(LOCK_CNT);

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic w_mon;

`ifdef CLK_MON_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= mon_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_mon = r_sync2;
`else
  assign w_mon = mon_in;
`endif

  // --------------------------------------------------------------------------
  // Rising-edge detect
  // --------------------------------------------------------------------------
  logic r_mon_q;
  logic w_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mon_q <= 1'b0;
    end else begin
      r_mon_q <= w_mon;
    end
  end

  assign w_rise = w_mon & ~r_mon_q;

  // --------------------------------------------------------------------------
  // Measurement state
  // --------------------------------------------------------------------------
  ch_state_t           r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [c_GOOD_W-1:0] r_good;
  logic [CNT_W-1:0]    r_period;
  logic                r_vld;
  logic                r_locked;
  logic                r_err;
  logic                r_timeout;

  logic [DIFF_W-1:0]   w_diff;
  logic                w_good;
  logic                w_sat;
  logic [c_GOOD_W-1:0] w_good_nxt;

  // r_cnt holds the number of clk cycles since the arming edge, so on a
  // rising edge it is exactly the period.
  assign w_diff     = abs_diff(32'(r_cnt), 32'(exp_period));
  assign w_good     = (w_diff <= DIFF_W'(tol));
  assign w_sat      = (r_state == ST_MEASURE) && (r_cnt == c_CNT_MAX);
  assign w_good_nxt = (r_good == c_LOCK) ? r_good : r_good + c_GOOD_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_good    <= '0;
      r_period  <= '0;
      r_vld     <= 1'b0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_vld <= 1'b0;

      // Clear first; any set event further down overrides it in the same
      // cycle, so a flag raised together with err_clr stays set.
      if (err_clr) begin
        r_err     <= 1'b0;
        r_timeout <= 1'b0;
      end

      if (!en) begin
        r_state  <= ST_IDLE;
        r_cnt    <= '0;
        r_good   <= '0;
        r_locked <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            // The first edge only arms the channel; no period is reported.
            if (w_rise) begin
              r_state <= ST_MEASURE;
              r_cnt   <= CNT_W'(1);
            end else begin
              r_cnt <= '0;
            end
          end

          ST_MEASURE: begin
            if (w_sat) begin
              r_timeout <= 1'b1;
              r_err     <= 1'b1;
              r_locked  <= 1'b0;
              r_good    <= '0;
              // An edge coinciding with saturation is not a valid period;
              // it is used as a fresh arming edge instead.
              if (w_rise) begin
                r_cnt <= CNT_W'(1);
              end else begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
              end
            end else if (w_rise) begin
              r_period <= r_cnt;
              r_vld    <= 1'b1;
              r_cnt    <= CNT_W'(1);
              if (w_good) begin
                r_good   <= w_good_nxt;
                r_locked <= (w_good_nxt == c_LOCK);
              end else begin
                r_err    <= 1'b1;
                r_locked <= 1'b0;
                r_good   <= '0;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end

          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign period_out = r_period;
  assign period_vld = r_vld;
  assign locked     = r_locked;
  assign err        = r_err;
  assign timeout    = r_timeout;

endmodule : clk_period_ch
`default_nettype wire

// File: rtl/clk_period_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : clk_period_monitor
// Purpose  : Multi-channel clock-period checker. Each bit of mon_in is an
//            independent channel measuring its rising-edge-to-rising-edge
//            interval in clk cycles against a shared exp_period +/- tol.
// Ports    : clk        - system clock
//            rst        - asynchronous active-high reset
//            en         - global enable; low forces all channels to IDLE
//            mon_in     - [NUM_CH] monitored signals
//            exp_period - [CNT_W] expected period, shared by all channels
//            tol        - [CNT_W] allowed absolute deviation, inclusive
//            err_clr    - [NUM_CH] per-channel sticky-flag clear
//            period_out - [NUM_CH*CNT_W] last period, channel i at
//                         bits [i*CNT_W +: CNT_W]
//            period_vld - [NUM_CH] one-cycle update pulse
//            locked     - [NUM_CH] LOCK_CNT consecutive good periods
//            err        - [NUM_CH] sticky error
//            timeout    - [NUM_CH] sticky timeout (clock stopped)
// Options  : CLK_MON_SYNC_EN - 2-flop synchronizer on every mon_in bit.
// Revision : 1.0 - initial release
// ============================================================================
module clk_period_monitor
  import clk_period_mon_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       mon_in,
  input  logic [CNT_W-1:0]        exp_period,
  input  logic [CNT_W-1:0]        tol,
  input  logic [NUM_CH-1:0]       err_clr,
  output logic [NUM_CH*CNT_W-1:0] period_out,
  output logic [NUM_CH-1:0]       period_vld,
  output logic [NUM_CH-1:0]       locked,
  output logic [NUM_CH-1:0]       err,
  output logic [NUM_CH-1:0]       timeout
);

  // Channels share only the compare settings and the enable; everything
  // else is private, so simultaneous events on several channels need no
  // arbitration.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_period_ch #(
      .CNT_W    (CNT_W),
      .LOCK_CNT (LOCK_CNT)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .mon_in     (mon_in[i]),
      .exp_period (exp_period),
      .tol        (tol),
      .err_clr    (err_clr[i]),
      .period_out (period_out[i*CNT_W +: CNT_W]),
      .period_vld (period_vld[i]),
      .locked     (locked[i]),
      .err        (err[i]),
      .timeout    (timeout[i])
    );
  end : g_ch

endmodule : clk_period_monitor
`default_nettype wire
